// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches from insmem and queues {pc, ins, fault} for decode.
// Redirects flush the queue; a faulting fetch halts until the next redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 400,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fault;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        out_q;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic          halted_q, halted_d, out_valid_q, fault, pop, push;
  assign fault = (pc_q[1:0] != 2'b00) | (pc_q > LAST_PC);
  assign pop   = out_valid_q & out_ready;
  assign push  = !halted_q & !redirect_valid & ((count_q < (AW+1)'(DEPTH)) | pop);
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = {pc_q, fault ? 32'h0 : imem_data, fault};
    head_d   = redirect_valid ? tail_q : head_q + AW'(pop);
    tail_d   = redirect_valid ? tail_q : tail_q + AW'(push);
    count_d  = redirect_valid ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    pc_d     = redirect_valid ? redirect_pc : (push & !fault) ? pc_q + 32'd4 : pc_q;
    halted_d = redirect_valid ? 1'b0 : (push & fault) ? 1'b1 : halted_q;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  // Output registers mirror the next head so out_* never depend combinationally on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= count_d != '0;
      if (count_d != '0) out_q <= mem_d[head_d];
    end
  end
  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_ins      = out_q.ins;
  assign out_fault    = out_q.fault;
  assign fetch_halted = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; tasks queue expected deliveries, a negedge monitor pops them.
module tb_fetch_stage;
  logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_addr, imem_data, out_pc, out_ins;
  logic        out_valid, out_fault, fetch_halted;
  int          checks = 0, errors = 0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        f;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] ins_at(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h0010_0113 : {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction
  assign imem_data = ins_at(imem_addr);
  fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(400), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_fault(out_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_halted(fetch_halted)
  );
  task automatic expect_entry(input logic [31:0] pc, input logic f);
    exp_q.push_back({pc, f ? 32'h0 : ins_at(pc), f});
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc=%h ins=%h fault=%b, required no delivery", out_pc, out_ins, out_fault);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_ins, out_fault} !== e) begin
          errors++;
          $display("FAIL delivery: got pc=%h ins=%h fault=%b, required pc=%h ins=%h fault=%b",
                   out_pc, out_ins, out_fault, e.pc, e.ins, e.f);
        end
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    #1 out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain: %0d entries undelivered, required 0", name, exp_q.size()); end
  endtask
  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, out_fault, fetch_halted, imem_addr, out_pc, out_ins} !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%b fault=%b halted=%b addr=%h pc=%h ins=%h, required all 0",
               out_valid, out_fault, fetch_halted, imem_addr, out_pc, out_ins);
    end
  endtask
  task automatic test_stream();
    do_reset();
    checks++;
    if (imem_addr !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_start: got addr=%h valid=%b, required 0 0", imem_addr, out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_entry(32'(4 * i), 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'(4 * i) || out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_step%0d: got addr=%h valid=%b, required %h 1", i, imem_addr, out_valid, 32'(4 * i));
      end
    end
    drain("stream");
  endtask
  task automatic test_back_to_back();
    do_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (imem_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL full_hold: got addr=%h valid=%b pc=%h, required 8 1 0", imem_addr, out_valid, out_pc);
    end
    for (int i = 0; i < 4; i++) expect_entry(32'(4 * i), 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap%0d: got valid=%b, required 1", i, out_valid); end
    end
    drain("b2b");
  endtask
  task automatic test_redirect_flush();
    do_reset();
    repeat (3) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    expect_entry(32'h0, 1'b0);
    expect_entry(32'h40, 1'b0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL flush: got valid=%b addr=%h, required 0 40", out_valid, imem_addr); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL flush_target: got valid=%b pc=%h, required 1 40", out_valid, out_pc); end
    drain("flush");
  endtask
  task automatic test_fault_end();
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    for (int a = 0; a <= 396; a += 4) expect_entry(32'(a), 1'b0);
    expect_entry(32'd400, 1'b1);
    while (!fetch_halted && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (fetch_halted !== 1'b1 || out_pc !== 32'd400 || out_fault !== 1'b1 || out_ins !== 32'h0) begin
      errors++; $display("FAIL end_fault: got halted=%b pc=%h fault=%b ins=%h, required 1 190 1 0", fetch_halted, out_pc, out_fault, out_ins);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'd400 || fetch_halted !== 1'b1) begin
      errors++; $display("FAIL halt_hold: got valid=%b addr=%h halted=%b, required 0 190 1", out_valid, imem_addr, fetch_halted);
    end
    expect_entry(32'h8, 1'b0);
    expect_entry(32'hC, 1'b0);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h8;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_halted !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL unhalt: got halted=%b addr=%h, required 0 8", fetch_halted, imem_addr); end
    drain("resume");
  endtask
  task automatic test_misaligned();
    do_reset();
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h6;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h6 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_addr: got addr=%h valid=%b, required 6 0", imem_addr, out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h6 || out_fault !== 1'b1 || out_ins !== 32'h0 || fetch_halted !== 1'b1) begin
      errors++; $display("FAIL mis_fault: got valid=%b pc=%h fault=%b ins=%h halted=%b, required 1 6 1 0 1",
                         out_valid, out_pc, out_fault, out_ins, fetch_halted);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (imem_addr !== 32'h6 || out_pc !== 32'h6) begin errors++; $display("FAIL mis_hold: got addr=%h pc=%h, required 6 6", imem_addr, out_pc); end
    expect_entry(32'h6, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    drain("mis");
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_single: got valid=%b, required 0", out_valid); end
  endtask
  task automatic test_async_reset();
    do_reset();
    repeat (3) @(posedge clk);
    checks++;
    if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL pre_reset: got valid=%b addr=%h, required 1 8", out_valid, imem_addr); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_halted !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid=%b addr=%h halted=%b, required 0 0 0", out_valid, imem_addr, fetch_halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expect_entry(32'h0, 1'b0);
    expect_entry(32'h4, 1'b0);
    out_ready = 1'b1;
    drain("after_reset");
  endtask
  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_redirect_flush();
    test_fault_end();
    test_misaligned();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
